// File: rtl/ac97_dma_arbiter.sv
// Purpose: round-robin arbiter sharing one Wishbone classic master between the
//          AC'97 playback (read) and record (write) DMA channels, with a
//          watchdog that aborts cycles the slave never acknowledges.
// Latency: request to cyc/stb 1 cycle; ack/err pulse the cycle after the bus
//          cycle ends; 3+k cycles per word for a slave with k wait states.
// Backpressure: requests are level-held and sampled only while idle; a request
//          arriving mid-transfer simply waits for the next idle cycle.
// Ports:
//   sys_clk/sys_rst      clock, asynchronous active-high reset
//   r_req/r_adr          playback read request, r_ack/r_err/r_dat response
//   w_req/w_adr/w_dat    record write request, w_ack/w_err response
//   busy                 high while a transfer is in progress
//   wbm_*                Wishbone classic master port
module ac97_dma_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        r_req,
  input  logic [29:0] r_adr,
  output logic        r_ack,
  output logic        r_err,
  output logic [31:0] r_dat,
  input  logic        w_req,
  input  logic [29:0] w_adr,
  input  logic [31:0] w_dat,
  output logic        w_ack,
  output logic        w_err,
  output logic        busy,
  output logic [31:0] wbm_adr_o,
  output logic [2:0]  wbm_cti_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [31:0] wbm_dat_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        last_q, last_d;      // 1: write channel was served last
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        expire;
  logic        grant_vld;
  logic        grant_w;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic        r_ack_q, r_ack_d;
  logic        r_err_q, r_err_d;
  logic        w_ack_q, w_ack_d;
  logic        w_err_q, w_err_d;
  logic        busy_q, busy_d;

  // Write wins only when it is alone or when read was served last.
  assign grant_vld = r_req | w_req;
  assign grant_w   = w_req & (~r_req | ~last_q);

  // Saturating increment: the watchdog never wraps back to zero.
  assign cnt_inc = (cnt_q == TMO) ? cnt_q : cnt_q + 8'd1;
  assign expire  = (cnt_inc == TMO);

  // State register and all registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 30'd0;
      wdat_q  <= 32'd0;
      rdat_q  <= 32'd0;
      r_ack_q <= 1'b0;
      r_err_q <= 1'b0;
      w_ack_q <= 1'b0;
      w_err_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      r_ack_q <= r_ack_d;
      r_err_q <= r_err_d;
      w_ack_q <= w_ack_d;
      w_err_q <= w_err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_BUS;
      S_BUS:   if (wbm_ack_i || expire) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    last_d  = last_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    r_ack_d = 1'b0;
    r_err_d = 1'b0;
    w_ack_d = 1'b0;
    w_err_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          we_d  = grant_w;
          adr_d = grant_w ? w_adr : r_adr;
          if (grant_w) wdat_d = w_dat;
          cyc_d = 1'b1;
          cnt_d = 8'd0;
        end
      end
      S_BUS: begin
        // Ack takes priority over a watchdog expiring in the same cycle.
        if (wbm_ack_i) begin
          cyc_d  = 1'b0;
          last_d = we_q;
          if (we_q) begin
            w_ack_d = 1'b1;
          end else begin
            r_ack_d = 1'b1;
            rdat_d  = wbm_dat_i;
          end
        end else begin
          cnt_d = cnt_inc;
          if (expire) begin
            cyc_d   = 1'b0;
            last_d  = we_q;
            w_err_d = we_q;
            r_err_d = ~we_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign r_ack     = r_ack_q;
  assign r_err     = r_err_q;
  assign r_dat     = rdat_q;
  assign w_ack     = w_ack_q;
  assign w_err     = w_err_q;
  assign busy      = busy_q;
  assign wbm_adr_o = {adr_q, 2'b00};
  assign wbm_cti_o = 3'b000;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_dat_o = wdat_q;

endmodule

// File: tb/tb_ac97_dma_arbiter.sv
// Purpose: scoreboard bench for ac97_dma_arbiter with a transaction-level
//          arbitration model, a programmable-wait Wishbone slave and a monitor.
// Latency: checks 1-cycle grant, ack/err the cycle after cyc drops, 1 idle gap.
// Backpressure: requesters hold req until their ack/err, then drop or refresh.
module tb_ac97_dma_arbiter;

  localparam int TMO = 4;

  typedef struct { logic [29:0] adr; logic [31:0] dat; int k; } req_t;
  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; } bus_t;
  typedef struct { logic [3:0] pulse; int len; logic [31:0] rdat; } rsp_t;
  typedef struct { int k; logic [31:0] dat; } slv_t;

  logic        sys_clk, sys_rst;
  logic        r_req, r_ack, r_err;
  logic [29:0] r_adr;
  logic [31:0] r_dat;
  logic        w_req, w_ack, w_err;
  logic [29:0] w_adr;
  logic [31:0] w_dat;
  logic        busy;
  logic [31:0] wbm_adr_o, wbm_dat_i, wbm_dat_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;

  req_t rd_q[$];
  req_t wr_q[$];
  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  slv_t slv_q[$];

  bit          model_last;   // 1: write served last
  logic [31:0] model_rdat;
  int vectors = 0;
  int miscompares = 0;

  ac97_dma_arbiter #(.TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .r_req(r_req), .r_adr(r_adr), .r_ack(r_ack), .r_err(r_err), .r_dat(r_dat),
    .w_req(w_req), .w_adr(w_adr), .w_dat(w_dat), .w_ack(w_ack), .w_err(w_err),
    .busy(busy),
    .wbm_adr_o(wbm_adr_o), .wbm_cti_o(wbm_cti_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  task automatic add_r(input logic [29:0] adr, input logic [31:0] dat, input int k);
    rd_q.push_back('{adr: adr, dat: dat, k: k});
  endtask

  task automatic add_w(input logic [29:0] adr, input logic [31:0] dat, input int k);
    wr_q.push_back('{adr: adr, dat: dat, k: k});
  endtask

  // Slave: acks after k wait states of the current cycle; k >= TMO never acks in time.
  initial begin
    slv_t cur;
    bit   have;
    int   bc;
    have = 0; bc = 0;
    cur = '{k: -1, dat: 32'd0};
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'd0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst || !wbm_cyc_o || wbm_ack_i) begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom;
        bc = 0;
        have = 0;
      end else begin
        if (!have) begin
          have = 1;
          if (slv_q.size() > 0) cur = slv_q.pop_front();
          else cur = '{k: -1, dat: 32'd0};
        end
        if (bc == cur.k) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = cur.dat;
        end else begin
          wbm_dat_i = $urandom;
        end
        bc++;
      end
    end
  end

  // Monitor: checks each bus cycle and each response against the scoreboard.
  initial begin
    bit         prev_cyc;
    int         len;
    bus_t       eb;
    rsp_t       er;
    logic [3:0] pl;
    prev_cyc = 0; len = 0;
    eb = '{we: 1'b0, adr: 32'd0, dat: 32'd0};
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        prev_cyc = 0;
        len = 0;
      end else begin
        pl = {r_ack, r_err, w_ack, w_err};
        if (wbm_cyc_o) begin
          if (!prev_cyc) begin
            len = 0;
            if (exp_bus.size() == 0) fail("unexpected_bus_cycle");
            else begin
              eb = exp_bus.pop_front();
              check("we", {31'd0, wbm_we_o}, {31'd0, eb.we});
              if (eb.we) check("wbm_dat_o", wbm_dat_o, eb.dat);
            end
          end
          len++;
          check("adr_stable", wbm_adr_o, eb.adr);
          check("stb", {31'd0, wbm_stb_o}, 32'd1);
          check("cti", {29'd0, wbm_cti_o}, 32'd0);
          check("busy_in_bus", {31'd0, busy}, 32'd1);
          check("pulse_in_bus", {28'd0, pl}, 32'd0);
        end else if (prev_cyc) begin
          if (exp_rsp.size() == 0) fail("unexpected_response");
          else begin
            er = exp_rsp.pop_front();
            check("ack_err_pulse", {28'd0, pl}, {28'd0, er.pulse});
            check("cyc_len", 32'(len), 32'(er.len));
            check("r_dat", r_dat, er.rdat);
            check("busy_in_done", {31'd0, busy}, 32'd1);
          end
        end else begin
          check("stray_pulse", {28'd0, pl}, 32'd0);
        end
        prev_cyc = wbm_cyc_o;
      end
    end
  end

  // Drives the pending requests of both channels; the model predicts the
  // whole grant sequence up front from the round-robin rule.
  task automatic run_round();
    int ri, wi, a, b, cyc_at, idle_at, done_at, guard;
    bit g, err;
    req_t x;
    a = 0; b = 0;
    while (a < rd_q.size() || b < wr_q.size()) begin
      if (a < rd_q.size() && b < wr_q.size()) g = ~model_last;
      else g = (b < wr_q.size());
      if (g) begin x = wr_q[b]; b++; end
      else begin x = rd_q[a]; a++; end
      err = (x.k >= TMO);
      exp_bus.push_back('{we: g, adr: {x.adr, 2'b00}, dat: x.dat});
      slv_q.push_back('{k: x.k, dat: x.dat});
      if (!g && !err) model_rdat = x.dat;
      exp_rsp.push_back('{pulse: g ? (err ? 4'b0001 : 4'b0010) : (err ? 4'b0100 : 4'b1000),
                          len: err ? TMO : x.k + 1, rdat: model_rdat});
      model_last = g;
    end

    ri = 0; wi = 0; guard = 0;
    cyc_at = 1; idle_at = -1; done_at = -1;
    @(negedge sys_clk);
    r_req = (rd_q.size() > 0);
    if (r_req) r_adr = rd_q[0].adr;
    w_req = (wr_q.size() > 0);
    if (w_req) begin w_adr = wr_q[0].adr; w_dat = wr_q[0].dat; end
    while (guard != done_at) begin
      @(negedge sys_clk);
      guard++;
      if (guard == cyc_at) check("grant_latency", {31'd0, wbm_cyc_o}, 32'd1);
      if (guard == idle_at) begin
        check("idle_gap_busy", {31'd0, busy}, 32'd0);
        check("idle_gap_cyc", {31'd0, wbm_cyc_o}, 32'd0);
      end
      if (r_ack || r_err || w_ack || w_err) begin
        if (r_ack || r_err) ri++;
        if (w_ack || w_err) wi++;
        r_req = (ri < rd_q.size());
        if (r_req) r_adr = rd_q[ri].adr;
        w_req = (wi < wr_q.size());
        if (w_req) begin w_adr = wr_q[wi].adr; w_dat = wr_q[wi].dat; end
        idle_at = guard + 1;
        if (r_req || w_req) cyc_at = guard + 2;
        else done_at = guard + 1;
      end
      if (guard > 300) begin
        fail("round_timeout");
        r_req = 1'b0;
        w_req = 1'b0;
        break;
      end
    end
    rd_q.delete();
    wr_q.delete();
  endtask

  initial begin
    int nr, nw;
    sys_rst = 1'b1;
    r_req = 1'b0; r_adr = 30'd0;
    w_req = 1'b0; w_adr = 30'd0; w_dat = 32'd0;
    model_last = 1'b1;
    model_rdat = 32'd0;
    repeat (3) @(negedge sys_clk);
    check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
    check("rst_we", {31'd0, wbm_we_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat_o", wbm_dat_o, 32'd0);
    check("rst_r_dat", r_dat, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {28'd0, r_ack, r_err, w_ack, w_err}, 32'd0);
    sys_rst = 1'b0;

    // Single read, zero-wait slave.
    add_r(30'h100, 32'hDEADBEEF, 0);
    run_round();
    // Single write, two wait states.
    add_w(30'h2, 32'h12345678, 2);
    run_round();
    // Contention: three of each held continuously.
    for (int i = 0; i < 3; i++) begin
      add_r(30'($urandom), $urandom, 0);
      add_w(30'($urandom), $urandom, 0);
    end
    run_round();
    // Read timeout, then a write.
    add_r(30'h3F0, 32'h0BAD0BAD, 1000);
    run_round();
    add_w(30'h77, 32'hCAFEF00D, 1);
    run_round();
    // Ack on the cycle the watchdog would expire.
    add_r(30'h55, 32'h13579BDF, TMO - 1);
    run_round();

    // Random rounds: mixed request counts and wait states, some timing out.
    for (int n = 0; n < 40; n++) begin
      nr = $urandom_range(0, 3);
      nw = $urandom_range(0, 3);
      if (nr + nw == 0) nr = 1;
      for (int i = 0; i < nr; i++) add_r(30'($urandom), $urandom, $urandom_range(0, TMO + 1));
      for (int i = 0; i < nw; i++) add_w(30'($urandom), $urandom, $urandom_range(0, TMO + 1));
      run_round();
    end

    // Reset in the middle of a write cycle.
    @(negedge sys_clk);
    exp_bus.push_back('{we: 1'b1, adr: {30'h155, 2'b00}, dat: 32'hA5A50F0F});
    slv_q.push_back('{k: 1000, dat: 32'd0});
    w_req = 1'b1; w_adr = 30'h155; w_dat = 32'hA5A50F0F;
    @(negedge sys_clk);
    @(negedge sys_clk);
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    check("midrst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("midrst_stb", {31'd0, wbm_stb_o}, 32'd0);
    check("midrst_we", {31'd0, wbm_we_o}, 32'd0);
    check("midrst_adr", wbm_adr_o, 32'd0);
    check("midrst_dat_o", wbm_dat_o, 32'd0);
    check("midrst_r_dat", r_dat, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pulses", {28'd0, r_ack, r_err, w_ack, w_err}, 32'd0);
    w_req = 1'b0;
    exp_bus.delete();
    exp_rsp.delete();
    slv_q.delete();
    model_last = 1'b1;
    model_rdat = 32'd0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    // Both pending after reset: read must go first.
    add_w(30'h155, 32'hA5A50F0F, 0);
    add_r(30'h2AA, 32'h5A5AF0F0, 0);
    run_round();

    repeat (3) @(negedge sys_clk);
    if (exp_bus.size() != 0 || exp_rsp.size() != 0) fail("scoreboard_not_drained");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
